// File: rtl/filt_pkg.sv
// Shared helpers for the CIC filter family: output width derivation and
// sign extension used by both the interpolator and the decimator.
package filt_pkg;

    localparam int unsigned EXT_W = 64;

    // Bit growth of an N-stage CIC with rate change R and differential delay M.
    function automatic int cic_width(input int inp_width, input int order,
                                     input int rate, input int diff_delay);
        return inp_width + order * $clog2(rate * diff_delay);
    endfunction

    // Replicates bit [width-1] of value into every bit above it.
    function automatic logic [EXT_W-1:0] sign_extend(input logic [EXT_W-1:0] value,
                                                     input int unsigned width);
        logic [EXT_W-1:0] keep;
        logic [EXT_W-1:0] shifted;
        keep    = {EXT_W{1'b1}} >> (EXT_W - width);
        shifted = value >> (width - 1);
        return shifted[0] ? (value | ~keep) : (value & keep);
    endfunction

endpackage

// File: rtl/dff.sv
// Enabled register cell with asynchronous active-low clear.
module dff #(
    parameter int gp_width = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_an,
    input  logic                i_ena,
    input  logic [gp_width-1:0] i_data,
    output logic [gp_width-1:0] o_data
);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_data <= '0;
        end else if (i_ena) begin
            o_data <= i_data;
        end
    end

endmodule

// File: rtl/filt_cicd_downsample.sv
// Rate reduction by R: owns the phase counter, emits the low-rate strobe and
// holds the selected sample together with its one-cycle valid pulse.
module filt_cicd_downsample #(
    parameter int gp_decimation_factor = 4,
    parameter int gp_phase             = 0,
    parameter int gp_width             = 14
) (
    input  logic                i_clk,
    input  logic                i_rst_an,
    input  logic                i_ena,
    input  logic [gp_width-1:0] i_data,
    output logic                o_strobe,
    output logic [gp_width-1:0] o_data,
    output logic                o_valid
);

    localparam int CW = $clog2(gp_decimation_factor);

    logic [CW-1:0] count;

    assign o_strobe = i_ena && (count == CW'(gp_phase));

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            count   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_strobe;
            if (i_ena) begin
                count <= (count == CW'(gp_decimation_factor - 1)) ? '0 : count + CW'(1);
            end
            if (o_strobe) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/shift_register.sv
// Enabled delay line of gp_depth words; o_data is the oldest stored word.
module shift_register #(
    parameter int gp_width = 1,
    parameter int gp_depth = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_an,
    input  logic                i_ena,
    input  logic [gp_width-1:0] i_data,
    output logic [gp_width-1:0] o_data
);

    logic [gp_depth-1:0][gp_width-1:0] stage;

    // NOTE: every stage is cleared on reset, unlike a RAM, because stale
    // history would leak into the comb differences after a reset.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            stage <= '0;
        end else if (i_ena) begin
            stage[0] <= i_data;
            for (int i = 1; i < gp_depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign o_data = stage[gp_depth-1];

endmodule

// File: rtl/filt_cicd.sv
// Hogenauer CIC decimator: N integrators at the input rate, decimate by R,
// then N combs with differential delay M clocked by the low-rate strobe.
module filt_cicd
    import filt_pkg::*;
#(
    parameter int gp_decimation_factor = 4,
    parameter int gp_order             = 3,
    parameter int gp_diff_delay        = 1,
    parameter int gp_phase             = 0,
    parameter int gp_inp_width         = 8,
    parameter int gp_oup_width         = cic_width(gp_inp_width, gp_order,
                                                   gp_decimation_factor, gp_diff_delay)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_an,
    input  logic                    i_ena,
    input  logic [gp_inp_width-1:0] i_data,
    output logic [gp_oup_width-1:0] o_data,
    output logic                    o_valid
);

    logic [gp_oup_width-1:0]                ext;
    logic                                   strobe;
    logic [gp_order-1:0][gp_oup_width-1:0]  integ;
    logic [gp_order:0][gp_oup_width-1:0]    comb;
    logic [gp_order-1:0][gp_oup_width-1:0]  dly;

    assign ext = gp_oup_width'(sign_extend(EXT_W'(i_data), gp_inp_width));

    // Integrators wrap freely; the combs cancel the wrap as long as the final
    // result fits gp_oup_width, which its derivation guarantees.
    for (genvar k = 0; k < gp_order; k++) begin : g_integ
        logic [gp_oup_width-1:0] src;
        if (k == 0) begin : g_first
            assign src = ext;
        end else begin : g_rest
            assign src = integ[k-1];
        end
        dff #(.gp_width(gp_oup_width)) u_reg (
            .i_clk    (i_clk),
            .i_rst_an (i_rst_an),
            .i_ena    (i_ena),
            .i_data   (integ[k] + src),
            .o_data   (integ[k])
        );
    end

    assign comb[0] = integ[gp_order-1];

    for (genvar k = 0; k < gp_order; k++) begin : g_comb
        shift_register #(
            .gp_width (gp_oup_width),
            .gp_depth (gp_diff_delay)
        ) u_dly (
            .i_clk    (i_clk),
            .i_rst_an (i_rst_an),
            .i_ena    (strobe),
            .i_data   (comb[k]),
            .o_data   (dly[k])
        );
        assign comb[k+1] = comb[k] - dly[k];
    end

    filt_cicd_downsample #(
        .gp_decimation_factor (gp_decimation_factor),
        .gp_phase             (gp_phase),
        .gp_width             (gp_oup_width)
    ) u_down (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_data   (comb[gp_order]),
        .o_strobe (strobe),
        .o_data   (o_data),
        .o_valid  (o_valid)
    );

endmodule

// File: tb/tb_filt_cicd.sv
// Scoreboard bench for filt_cicd: a default build (M=1, phase 0) and an M=2,
// phase 2 build share the stimulus; expectations come from cumulative sums
// and a binomial comb difference over the decimated sequence.
module tb_filt_cicd;

    localparam int N   = 3;
    localparam int R   = 4;
    localparam int W_A = 14;
    localparam int W_B = 17;

    int m_u[2] = '{1, 2};
    int p_u[2] = '{0, 2};
    int w_u[2] = '{W_A, W_B};

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena   = 1'b0;
    logic [7:0]     din   = '0;
    logic [W_A-1:0] out_a;
    logic           val_a;
    logic [W_B-1:0] out_b;
    logic           val_b;

    filt_cicd dut_a (
        .i_clk    (clk),
        .i_rst_an (rst_n),
        .i_ena    (ena),
        .i_data   (din),
        .o_data   (out_a),
        .o_valid  (val_a)
    );

    filt_cicd #(.gp_phase(2), .gp_diff_delay(2)) dut_b (
        .i_clk    (clk),
        .i_rst_an (rst_n),
        .i_ena    (ena),
        .i_data   (din),
        .o_data   (out_b),
        .o_valid  (val_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint value;
        int     stamp;
    } exp_t;

    exp_t   q[2][$];
    longint hist[2][$];
    longint s0, s1, s2;
    int     n_en;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    longint last_out[2];
    longint sum_out[2];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m = longint'(1) << w;
        longint r = v & (m - 1);
        return (r >= (m >> 1)) ? r - m : r;
    endfunction

    // y_j = sum_k (-1)^k C(N,k) s_{j-kM}, zero history before reset.
    function automatic longint comb_out(input int u);
        longint y = 0;
        longint c = 1;
        int     j = hist[u].size() - 1;
        for (int k = 0; k <= N; k++) begin
            int idx = j - k * m_u[u];
            if (idx >= 0) y += ((k % 2) ? -c : c) * hist[u][idx];
            c = c * (N - k) / (k + 1);
        end
        return y;
    endfunction

    task automatic reset_model();
        s0 = 0; s1 = 0; s2 = 0; n_en = 0;
        for (int u = 0; u < 2; u++) begin
            hist[u].delete();
            q[u].delete();
            last_out[u] = 0;
            sum_out[u]  = 0;
        end
    endtask

    task automatic drive(input bit e, input logic [7:0] x);
        @(posedge clk);
        #1;
        ena = e;
        din = x;
        if (e) begin
            for (int u = 0; u < 2; u++) begin
                if (n_en % R == p_u[u]) begin
                    exp_t item;
                    hist[u].push_back(s2);
                    item.value = wrap(comb_out(u), w_u[u]);
                    item.stamp = cyc + 1;
                    q[u].push_back(item);
                end
            end
            s2 += s1;
            s1 += s0;
            s0 += longint'($signed(x));
            n_en++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " out_a"}, longint'(out_a), 0);
        check({tag, " val_a"}, longint'(val_a), 0);
        check({tag, " out_b"}, longint'(out_b), 0);
        check({tag, " val_b"}, longint'(val_b), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared(tag);
        reset_model();
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        longint d[2];
        logic   v[2];
        exp_t   e;
        d[0] = longint'($signed(out_a));
        v[0] = val_a;
        d[1] = longint'($signed(out_b));
        v[1] = val_b;
        for (int u = 0; u < 2; u++) begin
            if (v[u]) begin
                if (q[u].size() == 0) begin
                    check($sformatf("u%0d valid_without_expect", u), longint'(q[u].size()), 1);
                end else begin
                    e = q[u].pop_front();
                    check($sformatf("u%0d valid_cycle", u), longint'(cyc), longint'(e.stamp));
                    check($sformatf("u%0d data", u), d[u], e.value);
                    last_out[u] = d[u];
                    sum_out[u] += d[u];
                end
            end else if (q[u].size() > 0 && q[u][0].stamp <= cyc) begin
                check($sformatf("u%0d missing_valid", u), longint'(v[u]), 1);
                void'(q[u].pop_front());
            end
        end
    end

    initial begin
        reset_model();
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (64) drive(1'b1, 8'd127);
        repeat (3) drive(1'b0, 8'd0);
        check("dc_pos a", last_out[0], 8128);
        check("dc_pos b", last_out[1], 65024);

        do_reset("rst_dcneg");
        repeat (64) drive(1'b1, 8'h80);
        repeat (3) drive(1'b0, 8'd0);
        check("dc_neg a", last_out[0], -8192);
        check("dc_neg b", last_out[1], -65536);

        do_reset("rst_imp");
        drive(1'b1, 8'd1);
        repeat (63) drive(1'b1, 8'd0);
        repeat (3) drive(1'b0, 8'd0);
        check("impulse_sum a", sum_out[0], 16);
        check("impulse_sum b", sum_out[1], 128);
        check("impulse_tail a", last_out[0], 0);
        check("impulse_tail b", last_out[1], 0);

        do_reset("rst_gate");
        repeat (64) begin
            drive(1'b1, 8'd100);
            drive(1'b0, 8'd100);
        end
        repeat (3) drive(1'b0, 8'd0);
        check("gated_dc a", last_out[0], 6400);
        check("gated_dc b", last_out[1], 51200);

        do_reset("rst_pre_mid");
        repeat (30) drive(1'b1, 8'd127);
        do_reset("rst_mid");
        repeat (64) drive(1'b1, 8'd127);
        repeat (3) drive(1'b0, 8'd0);
        check("post_reset_dc a", last_out[0], 8128);
        check("post_reset_dc b", last_out[1], 65024);

        repeat (1500) drive($urandom_range(0, 3) != 0, 8'($urandom));
        repeat (4) drive(1'b0, 8'd0);
        check("drain a", longint'(q[0].size()), 0);
        check("drain b", longint'(q[1].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
